display_scan: RTL

Time-multiplexed scan controller for the 4-digit seven-segment display. It holds a refresh divider and walks a digit index 0→1→2→3→0. For each index it presents the matching BCD nibble, the decimal-point request and a blank request to the digit driver directly downstream. It also owns frame-coherent sampling of the stopwatch time value and the half-second blink of the digit pair being adjusted.

---
 rtl/display_pkg.sv | 36 +++
 rtl/display_scan_tick_gen.sv | 33 +++
 rtl/display_scan.sv | 114 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment scan path.
// Digit index map, decimal-point position, adjust-pair encoding and small
// helpers used by display_scan. No ports (package).
package display_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t DIGIT_SEC_ONES = 2'd0;
  localparam digit_idx_t DIGIT_SEC_TENS = 2'd1;
  localparam digit_idx_t DIGIT_MIN_ONES = 2'd2;
  localparam digit_idx_t DIGIT_MIN_TENS = 2'd3;

  localparam digit_idx_t DP_INDEX = 2'd2;

  localparam logic ADJ_SEC = 1'b0;
  localparam logic ADJ_MIN = 1'b1;

  // Pick the BCD nibble for a digit index out of the packed time value.
  function automatic logic [3:0] nibble_at(input logic [15:0] d, input digit_idx_t idx);
    logic [3:0] n;
    case (idx)
      DIGIT_SEC_ONES: n = d[3:0];
      DIGIT_SEC_TENS: n = d[7:4];
      DIGIT_MIN_ONES: n = d[11:8];
      default:        n = d[15:12];
    endcase
    return n;
  endfunction

  // Seconds pair lives at indices 0/1, minutes pair at 2/3, so the upper
  // index bit identifies the pair directly.
  function automatic logic in_adj_pair(input digit_idx_t idx, input logic sel);
    return (idx[1] == ADJ_MIN) ? (sel == ADJ_MIN) : (sel == ADJ_SEC);
  endfunction

endpackage

// File: rtl/display_scan_tick_gen.sv
// tick_gen: modulo-N counter with a single-cycle enable output.
// Ports:
//   src_clk   - clock (rising edge)
//   src_rst_n - synchronous active-low reset
//   clr       - synchronous clear, holds the count at 0 and suppresses tick
//   en        - count enable
//   tick      - high in an enabled cycle where the count equals N-1
module tick_gen #(
  parameter int unsigned N = 4
) (
  input  logic src_clk,
  input  logic src_rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count;

  assign tick = en & ~clr & (count == LAST);

  always_ff @(posedge src_clk) begin
    if (!src_rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/display_scan.sv
// display_scan: time-multiplexed scan controller for a 4-digit 7-segment
// display. Walks the digit index 0..3, presents BCD nibble, decimal point
// and blank request for each slot, samples the time value once per frame and
// blinks the digit pair being adjusted.
// Configuration macro: DISPLAY_SCAN_SNAPSHOT_EN (frame-coherent snapshot of
// digits_in; undefined = live per-slot sampling).
// Ports:
//   src_clk, src_rst_n - clock, synchronous active-low reset
//   digits_in[15:0]    - {min_tens, min_ones, sec_tens, sec_ones}
//   adj_en, adj_sel    - adjust mode, pair select (0 = sec, 1 = min)
//   select[1:0]        - current digit index
//   digit_val[3:0]     - BCD nibble for select
//   dp                 - decimal point (index 2 only)
//   blank              - suppress the current digit
//   frame_start        - one-cycle pulse when select becomes 0
module display_scan
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 125
) (
  input  logic        src_clk,
  input  logic        src_rst_n,
  input  logic [15:0] digits_in,
  input  logic        adj_en,
  input  logic        adj_sel,
  output logic [1:0]  select,
  output logic [3:0]  digit_val,
  output logic        dp,
  output logic        blank,
  output logic        frame_start
);

  logic        refresh_tick;
  logic        wrap;
  logic        blink_tick;
  logic        blink_phase;
  logic        phase_next;
  digit_idx_t  sel_next;
  logic [3:0]  val_next;
  logic        blank_next;
  logic [15:0] scan_src;

  assign wrap = refresh_tick & (digit_idx_t'(select) == DIGIT_MIN_TENS);

  tick_gen #(.N(REFRESH_DIV)) u_refresh (
    .src_clk   (src_clk),
    .src_rst_n (src_rst_n),
    .clr       (1'b0),
    .en        (1'b1),
    .tick      (refresh_tick)
  );

  tick_gen #(.N(BLINK_DIV)) u_blink (
    .src_clk   (src_clk),
    .src_rst_n (src_rst_n),
    .clr       (~adj_en),
    .en        (wrap),
    .tick      (blink_tick)
  );

`ifdef DISPLAY_SCAN_SNAPSHOT_EN
  logic [15:0] snap;

  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      snap <= '0;
    end else if (wrap) begin
      snap <= digits_in;
    end
  end

  assign scan_src = snap;
`else
  assign scan_src = digits_in;
`endif

  always_ff @(posedge src_clk) begin
    if (!src_rst_n || !adj_en) begin
      blink_phase <= 1'b0;
    end else if (blink_tick) begin
      blink_phase <= ~blink_phase;
    end
  end

  always_comb begin
    sel_next   = digit_idx_t'(select) + 2'd1;
    // Use the phase that will hold for the new frame, so a phase change
    // lines up with the frame boundary instead of lagging one slot.
    phase_next = adj_en & (blink_phase ^ blink_tick);
    // The wrap slot shows the very sample being captured into snap.
    val_next   = wrap ? digits_in[3:0] : nibble_at(scan_src, sel_next);
    blank_next = adj_en & phase_next & in_adj_pair(sel_next, adj_sel);
  end

  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      select      <= '0;
      digit_val   <= '0;
      dp          <= 1'b0;
      blank       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (refresh_tick) begin
        select    <= sel_next;
        digit_val <= val_next;
        dp        <= (sel_next == DP_INDEX);
        blank     <= blank_next;
      end
    end
  end

endmodule
